// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions: active-low hex font, scan FSM states and digit count.
// The display driver uses the same font constant, so encoder and decoder stay in lockstep.
package seven_segment_pkg;

  localparam int unsigned NumDigits = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } state_e;

  // Index n holds the active-low pattern {a,b,c,d,e,f,g,h} for hex digit n, with h off.
  localparam logic [15:0][7:0] SegFont = {
    8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

  function automatic logic is_one_cold(input logic [NumDigits-1:0] sel);
    return ($countones(~sel) == 1);
  endfunction

  function automatic logic [1:0] cold_index(input logic [NumDigits-1:0] sel);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NumDigits; i++) begin
      if (!sel[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_font_decode.sv
// Combinational active-low segment pattern to hex nibble lookup; the decimal point is ignored.
module seg_font_decode
  import seven_segment_pkg::*;
(
  input  logic [7:0] i_pattern,
  output logic [3:0] o_nibble,
  output logic       o_valid
);

  logic [7:0] w_masked;

  assign w_masked = i_pattern | 8'h01;

  always_comb begin
    o_nibble = 4'h0;
    o_valid  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (w_masked == SegFont[i]) begin
        o_nibble = 4'(i);
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Recovers a 4-digit hex value from a multiplexed seven-segment scan: debounces each digit,
// assembles a frame from four captures, and publishes only clean frames.
module seven_segment_scan_decoder
  import seven_segment_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  abcdefgh,
  input  logic [3:0]  digit,
  output logic [15:0] number,
  output logic        number_valid,
  output logic        pattern_error,
  output logic        stale
);

  localparam int unsigned StaleW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] CntLast = 8'(STABLE_CYCLES - 1);
  localparam logic [StaleW-1:0] StaleMax = StaleW'(TIMEOUT_CYCLES);

  logic [7:0]           r_seg;
  logic [3:0]           r_dig;
  state_e               r_state;
  logic [3:0]           r_cand_dig;
  logic [7:0]           r_cand_seg;
  logic [7:0]           r_stab_cnt;
  logic [NumDigits-1:0] r_seen;
  logic [15:0]          r_shadow;
  logic                 r_frame_bad;
  logic                 r_multi_prev;
  logic [15:0]          r_number;
  logic                 r_number_valid;
  logic                 r_pattern_error;
  logic [StaleW-1:0]    r_stale_cnt;

  logic [7:0]           w_seg;
  logic                 w_blank;
  logic                 w_multi;
  logic [1:0]           w_idx;
  logic [3:0]           w_nibble;
  logic                 w_font_ok;
  state_e               w_state_nxt;
  logic [3:0]           w_cand_dig_nxt;
  logic [7:0]           w_cand_seg_nxt;
  logic [7:0]           w_cnt_nxt;
  logic [7:0]           w_cnt_inc;
  logic                 w_start;
  logic                 w_capture;
  logic                 w_multi_err;
  logic [NumDigits-1:0] w_seen_nxt;
  logic [15:0]          w_shadow_nxt;
  logic                 w_bad_nxt;
  logic                 w_publish;
  logic                 w_pat_err;
  logic [StaleW-1:0]    w_stale_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg <= 8'hFF;
      r_dig <= 4'hF;
    end else begin
      r_seg <= abcdefgh;
      r_dig <= digit;
    end
  end

  // Decimal point is forced off so it never restarts debouncing or affects decoding.
  assign w_seg     = r_seg | 8'h01;
  assign w_blank   = (r_dig == 4'hF);
  assign w_multi   = !w_blank && !is_one_cold(r_dig);
  assign w_idx     = cold_index(r_dig);
  assign w_cnt_inc = r_stab_cnt + 8'd1;

  seg_font_decode u_font_decode (
    .i_pattern(w_seg),
    .o_nibble (w_nibble),
    .o_valid  (w_font_ok)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_cand_dig_nxt = r_cand_dig;
    w_cand_seg_nxt = r_cand_seg;
    w_cnt_nxt      = r_stab_cnt;
    w_start        = 1'b0;
    w_capture      = 1'b0;
    w_multi_err    = 1'b0;
    if (w_multi) begin
      w_state_nxt = StIdle;
      w_multi_err = !r_multi_prev;
    end else begin
      unique case (r_state)
        StIdle: w_start = 1'b1;
        StSettle: begin
          if (w_blank) begin
            w_state_nxt = StIdle;
          end else if (r_dig != r_cand_dig || w_seg != r_cand_seg) begin
            w_cand_dig_nxt = r_dig;
            w_cand_seg_nxt = w_seg;
            w_cnt_nxt      = 8'd0;
          end else if (w_cnt_inc == CntLast) begin
            w_capture   = 1'b1;
            w_state_nxt = StHold;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        StHold: w_start = (r_dig != r_cand_dig);
        default: w_state_nxt = StIdle;
      endcase
      if (w_start) begin
        if (w_blank) begin
          w_state_nxt = StIdle;
        end else begin
          w_cand_dig_nxt = r_dig;
          w_cand_seg_nxt = w_seg;
          w_cnt_nxt      = 8'd0;
          if (STABLE_CYCLES == 1) begin
            w_capture   = 1'b1;
            w_state_nxt = StHold;
          end else begin
            w_state_nxt = StSettle;
          end
        end
      end
    end
  end

  always_comb begin
    w_seen_nxt   = r_seen;
    w_shadow_nxt = r_shadow;
    w_bad_nxt    = r_frame_bad || w_multi_err;
    w_publish    = 1'b0;
    w_pat_err    = w_multi_err;
    if (w_capture) begin
      if (w_font_ok) begin
        w_shadow_nxt[{w_idx, 2'b00} +: 4] = w_nibble;
        w_seen_nxt[w_idx]                 = 1'b1;
        if (&w_seen_nxt) begin
          w_seen_nxt = '0;
          w_publish  = !r_frame_bad;
          w_bad_nxt  = 1'b0;
        end
      end else begin
        w_pat_err = 1'b1;
        w_bad_nxt = 1'b1;
      end
    end
  end

  // Cleared by the publish decision itself so stale falls in the same cycle number_valid rises.
  always_comb begin
    if (w_publish) begin
      w_stale_nxt = '0;
    end else if (r_stale_cnt == StaleMax) begin
      w_stale_nxt = r_stale_cnt;
    end else begin
      w_stale_nxt = r_stale_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= StIdle;
      r_cand_dig      <= 4'hF;
      r_cand_seg      <= 8'hFF;
      r_stab_cnt      <= 8'd0;
      r_seen          <= '0;
      r_shadow        <= 16'h0000;
      r_frame_bad     <= 1'b0;
      r_multi_prev    <= 1'b0;
      r_number        <= 16'h0000;
      r_number_valid  <= 1'b0;
      r_pattern_error <= 1'b0;
      r_stale_cnt     <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_cand_dig      <= w_cand_dig_nxt;
      r_cand_seg      <= w_cand_seg_nxt;
      r_stab_cnt      <= w_cnt_nxt;
      r_seen          <= w_seen_nxt;
      r_shadow        <= w_shadow_nxt;
      r_frame_bad     <= w_bad_nxt;
      r_multi_prev    <= w_multi;
      r_number        <= w_publish ? w_shadow_nxt : r_number;
      r_number_valid  <= w_publish;
      r_pattern_error <= w_pat_err;
      r_stale_cnt     <= w_stale_nxt;
    end
  end

  assign number        = r_number;
  assign number_valid  = r_number_valid;
  assign pattern_error = r_pattern_error;
  assign stale         = (r_stale_cnt == StaleMax);

endmodule
